// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter-chain sequencer: FSM state codes,
// the internal button-event selector and the default debounce length.
package counter_ctrl_pkg;

    // FSM state codes, also driven out on the state port
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        LAP   = 3'd2,
        PAUSE = 3'd3,
        CLEAR = 3'd4,
        LOAD  = 3'd5
    } state_t;

    // The single button event acted on in a cycle after priority selection
    typedef enum logic [2:0] {
        EV_NONE = 3'd0,
        EV_CLR  = 3'd1,
        EV_LOAD = 3'd2,
        EV_RUN  = 3'd3,
        EV_LAP  = 3'd4
    } event_t;

    // Default number of consecutive ce1ms pulses a new button level must hold
    localparam int DEB_MS_DEFAULT = 20;

endpackage

// File: rtl/counter_ctrl_btn_debounce.sv
// One push-button path: two-flop synchroniser, ce1ms-paced debounce counter
// and a one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEB_MS = 20,
    parameter int DEB_W  = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce1ms,
    input  logic raw,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [DEB_W-1:0] cnt;

    // Synchronise, count stable ms of a differing level, flip and flag a press
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (ce1ms) begin
                if (cnt == DEB_W'(DEB_MS - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                    press <= ~level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/clear/load sequencer for the four-stage counter chain. Debounces
// the four buttons, gates the count tick into the first stage, issues the
// clear/load strobes and freezes the displayed value in lap mode.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DEB_MS      = DEB_MS_DEFAULT,
    parameter int DEB_W       = 5,
    parameter bit STOP_ON_OVF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce1ms,
    input  logic        tick,
    input  logic        btn_run,
    input  logic        btn_clr,
    input  logic        btn_lap,
    input  logic        btn_load,
    input  logic [15:0] cnt_q,
    input  logic        cnt_ceo,
    output logic        cnt_ce,
    output logic        cnt_clr,
    output logic        cnt_load,
    output logic [15:0] disp_dat,
    output logic [2:0]  state,
    output logic        ovf
);

    state_t      cur;
    event_t      ev;
    logic [15:0] hold;
    logic        press_run;
    logic        press_clr;
    logic        press_lap;
    logic        press_load;
    logic        ovf_hit;

    btn_debounce #(.DEB_MS(DEB_MS), .DEB_W(DEB_W)) u_deb_run (
        .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .raw(btn_run), .press(press_run)
    );
    btn_debounce #(.DEB_MS(DEB_MS), .DEB_W(DEB_W)) u_deb_clr (
        .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .raw(btn_clr), .press(press_clr)
    );
    btn_debounce #(.DEB_MS(DEB_MS), .DEB_W(DEB_W)) u_deb_lap (
        .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .raw(btn_lap), .press(press_lap)
    );
    btn_debounce #(.DEB_MS(DEB_MS), .DEB_W(DEB_W)) u_deb_load (
        .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .raw(btn_load), .press(press_load)
    );

    // Pick the one event acted on this cycle: clr beats load beats run beats lap
    always_comb begin
        ev = EV_NONE;
        if (press_clr) begin
            ev = EV_CLR;
        end else if (press_load) begin
            ev = EV_LOAD;
        end else if (press_run) begin
            ev = EV_RUN;
        end else if (press_lap) begin
            ev = EV_LAP;
        end
    end

    assign ovf_hit = STOP_ON_OVF & tick & cnt_ceo;

    // Sequencer FSM with the sticky overflow flag and the lap hold register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur  <= IDLE;
            ovf  <= 1'b0;
            hold <= '0;
        end else begin
            case (cur)
                IDLE: begin
                    case (ev)
                        EV_CLR:  cur <= CLEAR;
                        EV_LOAD: cur <= LOAD;
                        EV_RUN:  cur <= RUN;
                        default: ;
                    endcase
                end
                RUN: begin
                    case (ev)
                        EV_CLR: cur <= CLEAR;
                        EV_RUN: cur <= PAUSE;
                        EV_LAP: begin
                            cur  <= LAP;
                            hold <= cnt_q;
                        end
                        default: begin
                            if (ovf_hit) begin
                                cur <= PAUSE;
                                ovf <= 1'b1;
                            end
                        end
                    endcase
                end
                LAP: begin
                    case (ev)
                        EV_CLR: cur <= CLEAR;
                        EV_RUN: cur <= PAUSE;
                        EV_LAP: cur <= RUN;
                        default: begin
                            if (ovf_hit) begin
                                cur <= PAUSE;
                                ovf <= 1'b1;
                            end
                        end
                    endcase
                end
                PAUSE: begin
                    case (ev)
                        EV_CLR:  cur <= CLEAR;
                        EV_LOAD: cur <= LOAD;
                        EV_RUN:  cur <= RUN;
                        default: ;
                    endcase
                end
                CLEAR: begin
                    cur  <= IDLE;
                    ovf  <= 1'b0;
                    hold <= '0;
                end
                LOAD: begin
                    cur <= PAUSE;
                end
                default: begin
                    cur <= IDLE;
                end
            endcase
        end
    end

    assign state    = cur;
    assign cnt_ce   = tick & ((cur == RUN) | (cur == LAP));
    assign cnt_clr  = (cur == CLEAR);
    assign cnt_load = (cur == LOAD);
    assign disp_dat = (cur == LAP) ? hold : cnt_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl: directed scenarios with literal expectations,
// then randomized buttons/ticks/resets checked every cycle against a
// table-driven behavioural model.
module tb_counter_ctrl;

    localparam int DEB = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce1ms = 1'b0;
    logic        tick = 1'b0;
    logic        btn_run = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_load = 1'b0;
    logic [15:0] cnt_q = 16'h1234;
    logic        cnt_ceo = 1'b0;
    logic        cnt_ce;
    logic        cnt_clr;
    logic        cnt_load;
    logic [15:0] disp_dat;
    logic [2:0]  state;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    counter_ctrl #(.DEB_MS(DEB), .DEB_W(3), .STOP_ON_OVF(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .tick(tick),
        .btn_run(btn_run), .btn_clr(btn_clr), .btn_lap(btn_lap), .btn_load(btn_load),
        .cnt_q(cnt_q), .cnt_ceo(cnt_ceo), .cnt_ce(cnt_ce), .cnt_clr(cnt_clr),
        .cnt_load(cnt_load), .disp_dat(disp_dat), .state(state), .ovf(ovf)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // ce1ms: one-cycle pulse every 4 clocks
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            ce1ms = (div == 3);
            div = (div + 1) % 4;
        end
    end

    // Behavioural model. States 0..5 = IDLE,RUN,LAP,PAUSE,CLEAR,LOAD.
    // Events 0..4 = none,clr,load,run,lap. Buttons 0..3 = run,clr,lap,load.
    int          trans[6][5];
    int          m_state;
    bit          m_ovf;
    logic [15:0] m_hold;
    bit          m_valid = 1'b0;
    bit          m_s1[4];
    bit          m_s2[4];
    bit          m_lvl[4];
    bit          m_press[4];
    int          m_run[4];

    initial begin
        for (int s = 0; s < 6; s++)
            for (int e = 0; e < 5; e++)
                trans[s][e] = -1;
        trans[0][1] = 4; trans[0][2] = 5; trans[0][3] = 1;
        trans[1][1] = 4; trans[1][3] = 3; trans[1][4] = 2;
        trans[2][1] = 4; trans[2][3] = 3; trans[2][4] = 1;
        trans[3][1] = 4; trans[3][2] = 5; trans[3][3] = 1;
        for (int e = 0; e < 5; e++) begin
            trans[4][e] = 0;
            trans[5][e] = 3;
        end
    end

    always @(posedge clk) begin
        bit raw[4];
        int ev;
        int nxt;
        raw[0] = btn_run; raw[1] = btn_clr; raw[2] = btn_lap; raw[3] = btn_load;
        if (!rst_n) begin
            m_state = 0;
            m_ovf   = 1'b0;
            m_hold  = '0;
            m_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_press[i] = 0; m_run[i] = 0;
            end
        end else begin
            ev = m_press[1] ? 1 : m_press[3] ? 2 : m_press[0] ? 3 : m_press[2] ? 4 : 0;
            nxt = trans[m_state][ev];
            if (m_state == 4) begin
                m_ovf  = 1'b0;
                m_hold = '0;
            end
            if (nxt >= 0) begin
                if (m_state == 1 && ev == 4) m_hold = cnt_q;
                m_state = nxt;
            end else if ((m_state == 1 || m_state == 2) && tick && cnt_ceo) begin
                m_state = 3;
                m_ovf   = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                m_press[i] = 0;
                if (m_s2[i] == m_lvl[i]) begin
                    m_run[i] = 0;
                end else if (ce1ms) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i]   = !m_lvl[i];
                        m_run[i]   = 0;
                        m_press[i] = m_lvl[i];
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model state", 16'(state), 16'(m_state));
            checkOutput("model ovf", 16'(ovf), 16'(m_ovf));
            checkOutput("model cnt_ce", 16'(cnt_ce),
                        16'(tick && (m_state == 1 || m_state == 2)));
            checkOutput("model cnt_clr", 16'(cnt_clr), 16'(m_state == 4));
            checkOutput("model cnt_load", 16'(cnt_load), 16'(m_state == 5));
            checkOutput("model disp_dat", disp_dat, (m_state == 2) ? m_hold : cnt_q);
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the buttons in mask {load,lap,clr,run} for 12 clocks, release,
    // settle, and tally strobe cycles seen over the whole window
    task automatic applyStimulus(input logic [3:0] mask, output int nclr, output int nload);
        nclr = 0;
        nload = 0;
        btn_run = mask[0]; btn_clr = mask[1]; btn_lap = mask[2]; btn_load = mask[3];
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (cnt_clr) nclr++;
            if (cnt_load) nload++;
            @(posedge clk);
            #1;
            if (i == 11) begin
                btn_run = 0; btn_clr = 0; btn_lap = 0; btn_load = 0;
            end
        end
    endtask

    initial begin
        int nclr;
        int nload;
        int hold_t[4];
        bit lvl[4];

        // Reset state
        rst_n = 1'b0;
        stepCycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset state", 16'(state), 16'd0);
        checkOutput("reset ovf", 16'(ovf), 16'd0);
        checkOutput("reset cnt_ce", 16'(cnt_ce), 16'd0);
        checkOutput("reset strobes", 16'({cnt_clr, cnt_load}), 16'd0);
        checkOutput("reset disp_dat", disp_dat, 16'h1234);

        // Short glitch on run: no event
        stepCycles(1);
        btn_run = 1'b1;
        stepCycles(3);
        btn_run = 1'b0;
        stepCycles(16);
        @(negedge clk);
        checkOutput("glitch state", 16'(state), 16'd0);

        // Run press starts counting; cnt_ce follows tick
        applyStimulus(4'b0001, nclr, nload);
        @(negedge clk);
        checkOutput("run state", 16'(state), 16'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            tick = (i % 3 == 0);
            @(negedge clk);
            checkOutput("run cnt_ce", 16'(cnt_ce), 16'(i % 3 == 0));
        end
        @(posedge clk);
        #1;
        tick = 1'b0;

        // Lap freezes the display, second lap releases it
        applyStimulus(4'b0100, nclr, nload);
        @(negedge clk);
        checkOutput("lap state", 16'(state), 16'd2);
        @(posedge clk);
        #1;
        cnt_q = 16'h1236;
        @(negedge clk);
        checkOutput("lap frozen disp", disp_dat, 16'h1234);
        applyStimulus(4'b0100, nclr, nload);
        @(negedge clk);
        checkOutput("unlap state", 16'(state), 16'd1);
        checkOutput("unlap disp", disp_dat, 16'h1236);

        // Final carry with tick pauses and sets ovf
        @(posedge clk);
        #1;
        tick = 1'b1;
        cnt_ceo = 1'b1;
        stepCycles(1);
        @(negedge clk);
        checkOutput("ovf state", 16'(state), 16'd3);
        checkOutput("ovf flag", 16'(ovf), 16'd1);
        checkOutput("ovf cnt_ce", 16'(cnt_ce), 16'd0);
        @(posedge clk);
        #1;
        tick = 1'b0;
        cnt_ceo = 1'b0;
        applyStimulus(4'b0010, nclr, nload);
        checkOutput("clr pulse count", 16'(nclr), 16'd1);
        @(negedge clk);
        checkOutput("clr state", 16'(state), 16'd0);
        checkOutput("clr ovf", 16'(ovf), 16'd0);

        // clr beats load when simultaneous; lone load goes LOAD then PAUSE
        applyStimulus(4'b0001, nclr, nload);
        applyStimulus(4'b0001, nclr, nload);
        @(negedge clk);
        checkOutput("pause state", 16'(state), 16'd3);
        applyStimulus(4'b1010, nclr, nload);
        checkOutput("clr+load clr count", 16'(nclr), 16'd1);
        checkOutput("clr+load load count", 16'(nload), 16'd0);
        applyStimulus(4'b1000, nclr, nload);
        checkOutput("load pulse count", 16'(nload), 16'd1);
        @(negedge clk);
        checkOutput("load state", 16'(state), 16'd3);

        // Reset mid-run kills counting even with a tick present
        applyStimulus(4'b0001, nclr, nload);
        @(posedge clk);
        #1;
        tick = 1'b1;
        rst_n = 1'b0;
        stepCycles(1);
        @(negedge clk);
        checkOutput("rst state", 16'(state), 16'd0);
        checkOutput("rst cnt_ce", 16'(cnt_ce), 16'd0);
        checkOutput("rst strobes", 16'({cnt_clr, cnt_load}), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick = 1'b0;

        // Randomized phase
        for (int i = 0; i < 4; i++) begin
            hold_t[i] = 0;
            lvl[i] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hold_t[i] == 0) begin
                    lvl[i] = ($urandom_range(0, 2) == 0);
                    hold_t[i] = $urandom_range(1, 24);
                end else begin
                    hold_t[i]--;
                end
            end
            btn_run = lvl[0]; btn_clr = lvl[1]; btn_lap = lvl[2]; btn_load = lvl[3];
            tick = ($urandom_range(0, 2) == 0);
            cnt_ceo = ($urandom_range(0, 5) == 0);
            cnt_q = 16'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Run/pause/clear/load sequencer for the 4-stage counter chain: binary-mod-m, loadable up/down, decimal, Johnson.
- Debounces four push-buttons and gates the Nms/1s tick into the chain's first-stage enable.
- Issues one-cycle clear and load strobes to the chain.
- Provides a lap (freeze-display) function by muxing live or held 16-bit data toward DISPLAY.

Parameters:
- DEB_MS, 20, consecutive ce1ms pulses a raw button must hold a new level before the debounced level changes.
- DEB_W, 5, width of the debounce counter; must satisfy 2^DEB_W > DEB_MS.
- STOP_ON_OVF, 1, when 1 the FSM pauses and sets ovf when the chain's final carry fires.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- ce1ms  in  1  1 ms clock-enable pulse, one cycle wide
- tick  in  1  count-enable pulse from the Nms/1s generator
- btn_run  in  1  raw run/stop button, async, active high
- btn_clr  in  1  raw clear button
- btn_lap  in  1  raw lap button
- btn_load  in  1  raw load button
- cnt_q  in  16  concatenated chain outputs
- cnt_ceo  in  1  carry-out of the last chain stage
- cnt_ce  out  1  enable into first chain stage
- cnt_clr  out  1  clear strobe to all stages
- cnt_load  out  1  load strobe to the loadable stage
- disp_dat  out  16  data to DISPLAY
- state  out  3  current FSM state code
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset: all state updates on the clk rising edge while rst_n=0. Values: state=IDLE, ovf=0, hold=0, synchronisers=0, debounced levels=0, debounce counters=0. Outputs: cnt_clr=0, cnt_load=0, cnt_ce=0, disp_dat=cnt_q. Reset mid-operation aborts any state immediately; a pending strobe is not issued.
- Button path, per button:
  - 2-FF synchroniser.
  - Debounce counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments on ce1ms. When it reaches DEB_MS, the debounced level flips and the counter clears.
  - Press event = debounced 0->1, one clk cycle.
  - Release generates no event.
- Event priority when events coincide: clr > load > run > lap. Only the highest-priority event is acted on; the rest are dropped.
- State codes: IDLE=0, RUN=1, LAP=2, PAUSE=3, CLEAR=4, LOAD=5.
- Transitions:
  - IDLE: run->RUN; clr->CLEAR; load->LOAD; lap ignored.
  - RUN: run->PAUSE; clr->CLEAR; lap->LAP, capturing hold<=cnt_q in the same edge; load ignored.
  - LAP: lap->RUN; run->PAUSE; clr->CLEAR; load ignored.
  - PAUSE: run->RUN; clr->CLEAR; load->LOAD; lap ignored.
  - CLEAR: one cycle, then IDLE unconditionally. Clears ovf and hold.
  - LOAD: one cycle, then PAUSE unconditionally.
  - Events arriving during CLEAR/LOAD are dropped.
- Overflow: in RUN or LAP, if STOP_ON_OVF=1 and tick=1 and cnt_ceo=1, next state=PAUSE and ovf<=1. This applies only when no button event is accepted that cycle; a button event wins. ovf is sticky until CLEAR or reset.
- Outputs:
  - cnt_ce = tick AND (state==RUN or state==LAP). Combinational from the registered state, zero latency to tick.
  - cnt_clr = (state==CLEAR); cnt_load = (state==LOAD). Each is exactly one cycle, one cycle after the accepted event edge.
  - disp_dat = hold when state==LAP, else cnt_q.
  - state output = registered state code.
- Tick in the same cycle as an accepted run press in IDLE/PAUSE is not counted; counting starts with the next tick.

Decomposition:
- Shared package counter_ctrl_pkg holds the state codes IDLE..LOAD (3-bit) and the default DEB_MS.
- One sub-module, btn_debounce (sync + counter + edge), instantiated four times.
- FSM, hold register and output decode live in counter_ctrl.

Test Plan (all with DEB_MS=2 and ce1ms every 4 clk):
- Reset, then hold btn_run=1 for 12 clk -> exactly one run event; state 0->1; cnt_ce pulses once per tick thereafter.
- btn_run glitch high for 3 clk (under 2 ce1ms) -> no event, state stays 0.
- RUN with cnt_q=16'h1234, press lap -> state=2, disp_dat=16'h1234 frozen while cnt_q advances to 16'h1236; press lap -> state=1, disp_dat tracks cnt_q.
- RUN, force cnt_ceo=1 with tick=1 -> next cycle state=3, ovf=1, cnt_ce=0; then press clr -> cnt_clr high exactly 1 cycle, state=0, ovf=0.
- PAUSE, press clr and load simultaneously -> only cnt_clr pulses, cnt_load stays 0; then press load -> cnt_load 1 cycle, state=3.
- RUN, assert rst_n=0 for one edge -> state=0, cnt_ce=0 in the same cycle as a tick, no cnt_clr/cnt_load pulse.
